// File: rtl/ikaopll_acc_mixer_if.sv
// ---------------------------------------------------------------------------
// ikaopll_acc_mixer_if
//   Output sample stream of the accumulator/mixer, bundled as one interface.
//   The mixer itself keeps flat ports with fixed names. This bundle groups
//   the consumer side (sample, handshake, status) for whoever connects to it.
//
//   Signals:
//     sample   signed OUT_WIDTH  FIFO head sample
//     clip     1                 head sample was saturated
//     valid    1                 sample available
//     ready    1                 consumer accepts (pop)
//     overrun  1                 sticky "frame dropped" flag
//     ovr_clr  1                 clears overrun
// ---------------------------------------------------------------------------
interface ikaopll_acc_mixer_if #(
  parameter int OUT_WIDTH = 16
);
  logic signed [OUT_WIDTH-1:0] sample;
  logic                        clip;
  logic                        valid;
  logic                        ready;
  logic                        overrun;
  logic                        ovr_clr;

  // Producer side: the mixer.
  modport master (
    output sample, clip, valid, overrun,
    input  ready, ovr_clr
  );

  // Consumer side: the sink that takes samples and clears the flag.
  modport slave (
    input  sample, clip, valid, overrun,
    output ready, ovr_clr
  );
endinterface

// File: rtl/ikaopll_acc_mixer.sv
// ---------------------------------------------------------------------------
// ikaopll_acc_mixer
//   Per-slot operator output accumulator for the OPLL audio path. Each tick
//   converts the slot's sign/magnitude sample to a signed value. It scales
//   the value by the melody or rhythm volume and adds it to a wide frame
//   accumulator. At the frame-start slot (i_CYCLE_00) the finished frame sum
//   is saturated to OUT_WIDTH bits. The sum is then pushed into a 2-entry
//   output FIFO with a valid/ready handshake.
//
//   Optional feature (macro IKAOPLL_ACC_DCBLOCK_EN):
//     When defined, a first-order DC blocker sits between saturation and the
//     FIFO: y = x - x_prev + y_prev - (y_prev >>> 8). It is computed
//     OUT_WIDTH+2 bits wide, re-saturated to OUT_WIDTH, and its clip is ORed
//     into the clip bit. Without the macro no filter logic exists.
//
//   Ports:
//     i_EMUCLK        master clock
//     i_RST_n         asynchronous active-low reset
//     i_phi1_NCEN_n   active-low tick enable (gates the accumulator path)
//     i_CYCLE_00      frame-start slot marker
//     i_ACC_EN        slot carries audio
//     i_RO_CTRL       1 = rhythm slot (i_ROVOL), 0 = melody slot (i_MOVOL)
//     i_SIGN, i_MAG   sign/magnitude sample
//     i_MOVOL,i_ROVOL signed per-group volume
//     o_SAMPLE        signed FIFO head sample
//     o_CLIP          FIFO head was saturated
//     o_VALID         FIFO not empty
//     i_READY         consumer accepts head (any clock edge, not tick-gated)
//     o_OVERRUN       sticky: a frame was dropped because the FIFO was full
//     i_OVR_CLR       clears o_OVERRUN (any clock edge)
// ---------------------------------------------------------------------------
module ikaopll_acc_mixer #(
  parameter int SLOT_COUNT = 18,
  parameter int VOL_WIDTH  = 5,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                        i_EMUCLK,
  input  logic                        i_RST_n,
  input  logic                        i_phi1_NCEN_n,
  input  logic                        i_CYCLE_00,
  input  logic                        i_ACC_EN,
  input  logic                        i_RO_CTRL,
  input  logic                        i_SIGN,
  input  logic [7:0]                  i_MAG,
  input  logic signed [VOL_WIDTH-1:0] i_MOVOL,
  input  logic signed [VOL_WIDTH-1:0] i_ROVOL,
  output logic signed [OUT_WIDTH-1:0] o_SAMPLE,
  output logic                        o_VALID,
  input  logic                        i_READY,
  output logic                        o_CLIP,
  output logic                        o_OVERRUN,
  input  logic                        i_OVR_CLR
);

  localparam int PROD_W = 9 + VOL_WIDTH;
  localparam int ACC_W  = OUT_WIDTH + $clog2(SLOT_COUNT);

  typedef struct packed {
    logic                        clip;
    logic signed [OUT_WIDTH-1:0] sample;
  } entry_t;

  // -------------------------------------------------------------------------
  // Slot scaling
  // -------------------------------------------------------------------------
  logic                       w_tick;
  logic signed [8:0]          w_value;
  logic signed [VOL_WIDTH-1:0] w_vol;
  logic signed [PROD_W-1:0]   w_product;
  logic signed [ACC_W-1:0]    w_product_ext;

  assign w_tick = ~i_phi1_NCEN_n;

  // -(mag+1) is exactly the bitwise inverse of {0,mag} in 9-bit two's
  // complement, so the negative branch needs no adder.
  assign w_value       = i_SIGN ? ~{1'b0, i_MAG} : {1'b0, i_MAG};
  assign w_vol         = i_RO_CTRL ? i_ROVOL : i_MOVOL;
  assign w_product     = w_value * w_vol;
  assign w_product_ext = ACC_W'(w_product);

  // -------------------------------------------------------------------------
  // Frame accumulator
  // -------------------------------------------------------------------------
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_seen;      // one frame start observed since reset
  logic                    w_frame_close;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_acc  <= '0;
      r_seen <= 1'b0;
    end else if (w_tick) begin
      if (i_CYCLE_00) begin
        // The closing slot belongs to the next frame.
        r_acc  <= i_ACC_EN ? w_product_ext : '0;
        r_seen <= 1'b1;
      end else if (i_ACC_EN) begin
        r_acc <= r_acc + w_product_ext;
      end
    end
  end

  // Until a frame start has been seen, the accumulator holds a partial frame.
  // That partial frame is never emitted.
  assign w_frame_close = w_tick & i_CYCLE_00 & r_seen;

  // -------------------------------------------------------------------------
  // Saturation: in range iff all bits from the OUT_WIDTH sign bit up agree
  // -------------------------------------------------------------------------
  logic [ACC_W-OUT_WIDTH:0]    w_acc_upper;
  logic                        w_sat_clip;
  logic signed [OUT_WIDTH-1:0] w_sat;

  assign w_acc_upper = r_acc[ACC_W-1:OUT_WIDTH-1];
  assign w_sat_clip  = ~((&w_acc_upper) | ~(|w_acc_upper));
  assign w_sat       = w_sat_clip ? {r_acc[ACC_W-1], {(OUT_WIDTH-1){~r_acc[ACC_W-1]}}}
                                  : r_acc[OUT_WIDTH-1:0];

  entry_t w_push_data;

`ifdef IKAOPLL_ACC_DCBLOCK_EN
  // -------------------------------------------------------------------------
  // DC blocker. y_prev keeps the re-saturated output, so |y_prev| < 2^(OW-1)
  // and |x - x_prev| <= 2^OW. The internal sum therefore always fits OW+2 bits.
  // -------------------------------------------------------------------------
  localparam int DC_W = OUT_WIDTH + 2;

  logic signed [OUT_WIDTH-1:0] r_dc_x;
  logic signed [OUT_WIDTH-1:0] r_dc_y;
  logic signed [DC_W-1:0]      w_dc_y;
  logic [2:0]                  w_dc_upper;
  logic                        w_dc_clip;
  logic signed [OUT_WIDTH-1:0] w_dc_sat;

  assign w_dc_y = DC_W'(w_sat) - DC_W'(r_dc_x) + DC_W'(r_dc_y) - DC_W'(r_dc_y >>> 8);

  assign w_dc_upper = w_dc_y[DC_W-1:OUT_WIDTH-1];
  assign w_dc_clip  = ~((&w_dc_upper) | ~(|w_dc_upper));
  assign w_dc_sat   = w_dc_clip ? {w_dc_y[DC_W-1], {(OUT_WIDTH-1){~w_dc_y[DC_W-1]}}}
                                : w_dc_y[OUT_WIDTH-1:0];

  // Filter state advances once per emitted frame, even if the FIFO drops it.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_dc_x <= '0;
      r_dc_y <= '0;
    end else if (w_frame_close) begin
      r_dc_x <= w_sat;
      r_dc_y <= w_dc_sat;
    end
  end

  assign w_push_data.clip   = w_sat_clip | w_dc_clip;
  assign w_push_data.sample = w_dc_sat;
`else
  assign w_push_data.clip   = w_sat_clip;
  assign w_push_data.sample = w_sat;
`endif

  // -------------------------------------------------------------------------
  // 2-entry output FIFO. Pops are handshake-driven on every edge; pushes
  // happen only on frame-closing ticks.
  // -------------------------------------------------------------------------
  entry_t     r_mem [2];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;
  logic       r_ovr;

  logic w_pop;
  logic w_full;
  logic w_push_ok;
  logic w_drop;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_pop     = 1'b0;
    w_full    = 1'b0;
    w_push_ok = 1'b0;
    w_drop    = 1'b0;
    w_pop     = (r_count != 2'd0) & i_READY;
    w_full    = (r_count == 2'd2);
    if (w_frame_close) begin
      // When full, a same-edge pop frees the slot before the write.
      if (!w_full || w_pop) w_push_ok = 1'b1;
      else                  w_drop    = 1'b1;
    end
  end

  // NOTE: the two storage entries are reset on purpose. The head is visible
  // on o_SAMPLE/o_CLIP, and those must read 0 out of reset. Bulk memories
  // normally stay unreset.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop};
      // A new drop on the same edge as a clear keeps the flag set.
      r_ovr   <= w_drop | (r_ovr & ~i_OVR_CLR);
    end
  end

  assign o_SAMPLE  = r_mem[r_rd_ptr].sample;
  assign o_CLIP    = r_mem[r_rd_ptr].clip;
  assign o_VALID   = (r_count != 2'd0);
  assign o_OVERRUN = r_ovr;

endmodule

// File: tb/tb_ikaopll_acc_mixer.sv
module tb_ikaopll_acc_mixer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ncen_n;
  logic       cyc00;
  logic       acc_en;
  logic       ro_ctrl;
  logic       sgn;
  logic [7:0] mag;
  logic signed [4:0] movol;
  logic signed [4:0] rovol;

  int n_vec = 0;
  int n_err = 0;

  ikaopll_acc_mixer_if #(.OUT_WIDTH(16)) sbus ();

  ikaopll_acc_mixer #(
    .SLOT_COUNT(18),
    .VOL_WIDTH (5),
    .OUT_WIDTH (16)
  ) dut (
    .i_EMUCLK     (clk),
    .i_RST_n      (rst_n),
    .i_phi1_NCEN_n(ncen_n),
    .i_CYCLE_00   (cyc00),
    .i_ACC_EN     (acc_en),
    .i_RO_CTRL    (ro_ctrl),
    .i_SIGN       (sgn),
    .i_MAG        (mag),
    .i_MOVOL      (movol),
    .i_ROVOL      (rovol),
    .o_SAMPLE     (sbus.sample),
    .o_VALID      (sbus.valid),
    .i_READY      (sbus.ready),
    .o_CLIP       (sbus.clip),
    .o_OVERRUN    (sbus.overrun),
    .i_OVR_CLR    (sbus.ovr_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One tick-enabled clock edge with the given slot inputs.
  task automatic tick(input logic c, input logic e, input logic r,
                      input logic s, input logic [7:0] m);
    cyc00 = c; acc_en = e; ro_ctrl = r; sgn = s; mag = m; ncen_n = 1'b0;
    @(posedge clk); #1;
    cyc00 = 1'b0; acc_en = 1'b0;
  endtask

  // Full 18-slot frame; slot 0 carries CYCLE_00 (closing the previous frame).
  task automatic send_frame(input logic s, input logic [7:0] m,
                            input logic r, input int n_active);
    for (int k = 0; k < 18; k++) tick(k == 0, k < n_active, r, s, m);
  endtask

  // Non-tick edge with READY high: pops the head only.
  task automatic pop_one();
    sbus.ready = 1'b1; ncen_n = 1'b1;
    @(posedge clk); #1;
    sbus.ready = 1'b0; ncen_n = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_vec++; if (sbus.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", sbus.valid); end
    n_vec++; if (sbus.sample !== 16'sd0) begin n_err++; $display("FAIL reset_sample: got %0d want 0", sbus.sample); end
    n_vec++; if (sbus.clip !== 1'b0) begin n_err++; $display("FAIL reset_clip: got %b want 0", sbus.clip); end
    n_vec++; if (sbus.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", sbus.overrun); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Partial first frame followed by the first frame start: nothing is pushed.
    sbus.ready = 1'b0;
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd50);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    n_vec++; if (sbus.valid !== 1'b0) begin n_err++; $display("FAIL first_frame_discard: valid got %b want 0", sbus.valid); end
  endtask

  task automatic test_melody();
    movol = 5'sd4;
    sbus.ready = 1'b1;
    send_frame(1'b0, 8'd100, 1'b0, 18);
    sbus.ready = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    n_vec++; if (sbus.valid !== 1'b1) begin n_err++; $display("FAIL melody_valid: got %b want 1", sbus.valid); end
    n_vec++; if (sbus.sample !== 16'sd7200) begin n_err++; $display("FAIL melody_sample: got %0d want 7200", sbus.sample); end
    n_vec++; if (sbus.clip !== 1'b0) begin n_err++; $display("FAIL melody_clip: got %b want 0", sbus.clip); end
    // Held stable across idle non-tick edges without READY.
    ncen_n = 1'b1; @(posedge clk); @(posedge clk); #1; ncen_n = 1'b0;
    n_vec++; if (sbus.sample !== 16'sd7200) begin n_err++; $display("FAIL melody_hold: got %0d want 7200", sbus.sample); end
    pop_one();
    n_vec++; if (sbus.valid !== 1'b0) begin n_err++; $display("FAIL melody_pop_empty: valid got %b want 0", sbus.valid); end
  endtask

  task automatic test_rhythm();
    movol = 5'sd4;
    rovol = -5'sd1;
    // Mixed frame: rhythm (-1)*(-1)=+1, melody (-11)*4=-44, gated edge ignored.
    sbus.ready = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 8'd10);
    cyc00 = 1'b0; acc_en = 1'b1; ro_ctrl = 1'b0; sgn = 1'b0; mag = 8'd100; ncen_n = 1'b1;
    @(posedge clk); #1;
    acc_en = 1'b0; ncen_n = 1'b0;
    sbus.ready = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    n_vec++; if (sbus.sample !== -16'sd43) begin n_err++; $display("FAIL mixed_sample: got %0d want -43", sbus.sample); end
    pop_one();
    // One active rhythm slot per frame.
    sbus.ready = 1'b1;
    send_frame(1'b1, 8'd0, 1'b1, 1);
    sbus.ready = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    n_vec++; if (sbus.sample !== 16'sd1) begin n_err++; $display("FAIL rhythm_sample: got %0d want 1", sbus.sample); end
    n_vec++; if (sbus.clip !== 1'b0) begin n_err++; $display("FAIL rhythm_clip: got %b want 0", sbus.clip); end
    pop_one();
  endtask

  task automatic test_clip();
    movol = 5'sd15;
    sbus.ready = 1'b1;
    send_frame(1'b0, 8'd255, 1'b0, 18);           // +68850
    sbus.ready = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    n_vec++; if (sbus.sample !== 16'sd32767) begin n_err++; $display("FAIL clip_pos_sample: got %0d want 32767", sbus.sample); end
    n_vec++; if (sbus.clip !== 1'b1) begin n_err++; $display("FAIL clip_pos_flag: got %b want 1", sbus.clip); end
    pop_one();
    sbus.ready = 1'b1;
    send_frame(1'b1, 8'd255, 1'b0, 18);           // -69120
    sbus.ready = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    n_vec++; if (sbus.sample !== -16'sd32768) begin n_err++; $display("FAIL clip_neg_sample: got %0d want -32768", sbus.sample); end
    n_vec++; if (sbus.clip !== 1'b1) begin n_err++; $display("FAIL clip_neg_flag: got %b want 1", sbus.clip); end
    pop_one();
    // Exactly -32768: 8*(255*-16) + 8*-16 = -32768, no clip.
    movol = -5'sd16;
    sbus.ready = 1'b1;
    for (int k = 0; k < 18; k++) tick(k == 0, k < 9, 1'b0, 1'b0, (k < 8) ? 8'd255 : 8'd8);
    sbus.ready = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    n_vec++; if (sbus.sample !== -16'sd32768) begin n_err++; $display("FAIL edge_neg_sample: got %0d want -32768", sbus.sample); end
    n_vec++; if (sbus.clip !== 1'b0) begin n_err++; $display("FAIL edge_neg_clip: got %b want 0", sbus.clip); end
    pop_one();
    // 8*(-256*-16) = +32768, one past the top: clips.
    sbus.ready = 1'b1;
    send_frame(1'b1, 8'd255, 1'b0, 8);
    sbus.ready = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    n_vec++; if (sbus.sample !== 16'sd32767) begin n_err++; $display("FAIL edge_pos_sample: got %0d want 32767", sbus.sample); end
    n_vec++; if (sbus.clip !== 1'b1) begin n_err++; $display("FAIL edge_pos_clip: got %b want 1", sbus.clip); end
    pop_one();
  endtask

  task automatic test_overrun();
    movol = 5'sd1;
    sbus.ready = 1'b1;
    send_frame(1'b0, 8'd10, 1'b0, 18);            // frame 1 = 180
    sbus.ready = 1'b0;
    send_frame(1'b0, 8'd20, 1'b0, 18);            // push 180, frame 2 = 360
    send_frame(1'b0, 8'd30, 1'b0, 18);            // push 360, frame 3 = 540
    n_vec++; if (sbus.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_not_yet: got %b want 0", sbus.overrun); end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);           // frame 3 dropped
    n_vec++; if (sbus.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", sbus.overrun); end
    n_vec++; if (sbus.sample !== 16'sd180) begin n_err++; $display("FAIL ovr_head1: got %0d want 180", sbus.sample); end
    sbus.ovr_clr = 1'b1; ncen_n = 1'b1;
    @(posedge clk); #1;
    sbus.ovr_clr = 1'b0; ncen_n = 1'b0;
    n_vec++; if (sbus.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", sbus.overrun); end
    pop_one();
    n_vec++; if (sbus.sample !== 16'sd360) begin n_err++; $display("FAIL ovr_head2: got %0d want 360", sbus.sample); end
    pop_one();
    n_vec++; if (sbus.valid !== 1'b0) begin n_err++; $display("FAIL ovr_drained: valid got %b want 0", sbus.valid); end
  endtask

  task automatic test_back_to_back();
    movol = 5'sd1;
    sbus.ready = 1'b1;
    send_frame(1'b0, 8'd1, 1'b0, 18);             // 18
    sbus.ready = 1'b0;
    send_frame(1'b0, 8'd2, 1'b0, 18);             // push 18, acc 36
    send_frame(1'b0, 8'd3, 1'b0, 18);             // push 36, acc 54 -> full
    sbus.ready = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);           // pop 18 and push 54 together
    sbus.ready = 1'b0;
    n_vec++; if (sbus.sample !== 16'sd36) begin n_err++; $display("FAIL b2b_head: got %0d want 36", sbus.sample); end
    n_vec++; if (sbus.overrun !== 1'b0) begin n_err++; $display("FAIL b2b_no_ovr: got %b want 0", sbus.overrun); end
    sbus.ovr_clr = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);           // drop while clearing
    sbus.ovr_clr = 1'b0;
    n_vec++; if (sbus.overrun !== 1'b1) begin n_err++; $display("FAIL b2b_ovr_wins: got %b want 1", sbus.overrun); end
    pop_one();
    n_vec++; if (sbus.sample !== 16'sd54) begin n_err++; $display("FAIL b2b_head2: got %0d want 54", sbus.sample); end
    pop_one();
    n_vec++; if (sbus.valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: valid got %b want 0", sbus.valid); end
    sbus.ovr_clr = 1'b1; ncen_n = 1'b1;
    @(posedge clk); #1;
    sbus.ovr_clr = 1'b0; ncen_n = 1'b0;
  endtask

  task automatic test_reset_mid();
    movol = 5'sd1;
    sbus.ready = 1'b1;
    for (int k = 0; k < 9; k++) tick(k == 0, 1'b1, 1'b0, 1'b0, 8'd5);
    rst_n = 1'b0;
    #2;
    n_vec++; if (sbus.valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", sbus.valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 9; k < 18; k++) tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
    sbus.ready = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);           // first frame start: no push
    n_vec++; if (sbus.valid !== 1'b0) begin n_err++; $display("FAIL midrst_no_push: valid got %b want 0", sbus.valid); end
    for (int k = 1; k < 18; k++) tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);           // second frame start: push 85
    n_vec++; if (sbus.valid !== 1'b1) begin n_err++; $display("FAIL midrst_push: valid got %b want 1", sbus.valid); end
    n_vec++; if (sbus.sample !== 16'sd85) begin n_err++; $display("FAIL midrst_sample: got %0d want 85", sbus.sample); end
    pop_one();
  endtask

`ifdef IKAOPLL_ACC_DCBLOCK_EN
  task automatic test_dcblock();
    int x, xp, y, yp, prev;
    logic signed [15:0] e;
    rst_n = 1'b0;
    #12;
    @(posedge clk); #1;
    rst_n = 1'b1;
    movol = 5'sd8;
    sbus.ready = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd125);         // frame sum 125*8 = 1000
    for (int k = 1; k < 18; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    x = 1000; xp = 0; yp = 0; prev = 32767;
    for (int f = 0; f < 6; f++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, 8'd125);
      y = x - xp + yp - (yp >>> 8);
      e = y[15:0];
      n_vec++; if (sbus.sample !== e) begin n_err++; $display("FAIL dc_frame%0d: got %0d want %0d", f, sbus.sample, e); end
      n_vec++; if (!(sbus.sample < prev && sbus.sample > 0)) begin n_err++; $display("FAIL dc_monotonic%0d: got %0d prev %0d", f, sbus.sample, prev); end
      prev = sbus.sample;
      xp = x; yp = y;
      pop_one();
      for (int k = 1; k < 18; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; ncen_n = 1'b1; cyc00 = 1'b0; acc_en = 1'b0; ro_ctrl = 1'b0;
    sgn = 1'b0; mag = 8'd0; movol = 5'sd0; rovol = 5'sd0;
    sbus.ready = 1'b0; sbus.ovr_clr = 1'b0;
    test_reset();
`ifdef IKAOPLL_ACC_DCBLOCK_EN
    test_dcblock();
`else
    test_melody();
    test_rhythm();
    test_clip();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
